datapath_issue_decoder: RTL

//  Front end for the datapath: accepts a stream of 32-bit instruction words over a valid/ready handshake.

---
 rtl/datapath_issue_decoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/datapath_issue_decoder.sv
// Instruction front end: assembles 2- or 3-word instructions from a valid/ready word stream
// and issues one registered control bundle to the datapath.
module datapath_issue_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [2:0]       op,
    output logic             form,
    output logic [1:0]       vec,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [3:0]       C,
    output logic [3:0]       D,
    output logic [3:0]       zero_reg,
    output logic [3:0]       Y1,
    output logic [3:0]       Y2,
    output logic [1:0]       write,
    output logic             const_a,
    output logic [31:0]      constant,
    output logic             issue,
    output logic             err,
    output logic [CNT_W-1:0] icount
);

    typedef struct packed {
        logic [2:0]  op;
        logic        form;
        logic [1:0]  vec;
        logic [1:0]  write;
        logic        const_a;
        logic        rsvd_hi;
        logic [3:0]  zero_reg;
        logic [17:0] rsvd_lo;
    } w0_t;

    typedef struct packed {
        logic [7:0] rsvd;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] y1;
        logic [3:0] y2;
    } w1_t;

    typedef enum logic [1:0] {
        S_W0 = 2'd0,
        S_W1 = 2'd1,
        S_W2 = 2'd2
    } state_t;

    state_t state;
    w0_t    w0_q;
    w1_t    w1_q;
    w1_t    w1_cur;
    logic   accept;
    logic   complete;
    logic   malformed;

    assign instr_ready = ~stall & ~flush;
    assign accept      = instr_valid & instr_ready;

    // Operand word comes from the live bus for 2-word forms, from the shadow when W2 closes it.
    always_comb begin
        w1_cur    = w1_t'(instr);
        complete  = 1'b0;
        if (state == S_W2) begin
            w1_cur = w1_q;
        end
        if (accept) begin
            complete = ((state == S_W1) && !w0_q.const_a) || (state == S_W2);
        end
        malformed = w0_q.rsvd_hi | (|w0_q.rsvd_lo) | (|w1_cur.rsvd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_W0;
            w0_q     <= '0;
            w1_q     <= '0;
            op       <= '0;
            form     <= 1'b0;
            vec      <= '0;
            A        <= '0;
            B        <= '0;
            C        <= '0;
            D        <= '0;
            zero_reg <= '0;
            Y1       <= '0;
            Y2       <= '0;
            write    <= '0;
            const_a  <= 1'b0;
            constant <= '0;
            issue    <= 1'b0;
            err      <= 1'b0;
            icount   <= '0;
        end else begin
            write <= '0;
            issue <= 1'b0;

            // Flush drops ready, so it can never coincide with an accepted word.
            if (flush) begin
                state <= S_W0;
            end else if (accept) begin
                case (state)
                    S_W0: begin
                        w0_q  <= w0_t'(instr);
                        state <= S_W1;
                    end
                    S_W1: begin
                        w1_q  <= w1_t'(instr);
                        state <= w0_q.const_a ? S_W2 : S_W0;
                    end
                    S_W2:    state <= S_W0;
                    default: state <= S_W0;
                endcase
            end

            if (complete) begin
                op       <= w0_q.op;
                form     <= w0_q.form;
                vec      <= w0_q.vec;
                zero_reg <= w0_q.zero_reg;
                const_a  <= w0_q.const_a;
                A        <= w1_cur.a;
                B        <= w1_cur.b;
                C        <= w1_cur.c;
                D        <= w1_cur.d;
                Y1       <= w1_cur.y1;
                Y2       <= w1_cur.y2;
                if (state == S_W2) begin
                    constant <= instr;
                end
                if (malformed) begin
                    err <= 1'b1;
                end else begin
                    write  <= w0_q.write;
                    issue  <= 1'b1;
                    icount <= icount + CNT_W'(1);
                end
            end
        end
    end

endmodule
